// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time over a
// req/gnt + rvalid handshake and presents fetched words to decode through an output
// register backed by a one-entry skid register. Handles redirect, stall and halt.
module if_fetch #(
  parameter int unsigned     PC_W      = 22,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc_out,
  output logic            halted
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALTED
  } state_t;

  state_t          state, state_n;
  logic            discard, discard_n;
  logic            halt_pend, halt_pend_n;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] issue_pc;
  logic [PC_W-1:0] skid_pc;
  logic [31:0]     skid_data;
  logic            skid_valid;

  logic live;        // redirect/halt only act before the fetch has halted
  logic accept_gnt;  // request granted this cycle
  logic in_flight;   // a request is still outstanding after this cycle
  logic flush;       // redirect or halt empties the output side
  logic take_word;   // returned word is kept this cycle
  logic out_adv;     // output register may take a new value

  assign live       = (state != HALTED);
  assign accept_gnt = (state == REQ) && imem_gnt;
  assign in_flight  = accept_gnt || ((state == WAIT) && !imem_rvalid);
  assign flush      = live && (redirect || halt);
  assign take_word  = (state == WAIT) && imem_rvalid && !discard && !flush;
  assign out_adv    = !stall || !instr_valid;

  // State register with discard / pending-halt flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      discard   <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_n;
      discard   <= discard_n;
      halt_pend <= halt_pend_n;
    end
  end

  // Next-state: normal fetch sequencing, then redirect/halt overrides.
  // An outstanding request is never abandoned: the FSM stays in WAIT with discard
  // set so the late rvalid is swallowed before moving on or halting.
  always_comb begin
    state_n     = state;
    discard_n   = discard;
    halt_pend_n = halt_pend;
    case (state)
      IDLE: state_n = REQ;
      REQ:  if (imem_gnt) state_n = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (discard) begin
            discard_n   = 1'b0;
            halt_pend_n = 1'b0;
            state_n     = halt_pend ? HALTED : REQ;
          end else begin
            state_n = out_adv ? REQ : HOLD;
          end
        end
      end
      HOLD:    if (out_adv) state_n = REQ;
      HALTED:  state_n = HALTED;
      default: state_n = IDLE;
    endcase
    if (live && redirect) begin
      halt_pend_n = 1'b0;
      discard_n   = in_flight;
      state_n     = in_flight ? WAIT : REQ;
    end else if (live && halt) begin
      halt_pend_n = in_flight;
      discard_n   = in_flight;
      state_n     = in_flight ? WAIT : HALTED;
    end
  end

  // Memory-side and status outputs decoded from state
  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
    halted    = (state == HALTED);
  end

  // PC, issued-address capture, output register and skid register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      issue_pc    <= '0;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
    end else begin
      if (accept_gnt) begin
        pc       <= pc + PC_W'(1);
        issue_pc <= pc;
      end
      if (live && redirect) begin
        pc <= redirect_pc;
      end
      if (flush) begin
        instr       <= NOP_INSTR;
        instr_valid <= 1'b0;
        skid_valid  <= 1'b0;
      end else if (out_adv) begin
        if (skid_valid) begin
          instr       <= skid_data;
          pc_out      <= skid_pc;
          instr_valid <= 1'b1;
          skid_valid  <= 1'b0;
        end else if (take_word) begin
          instr       <= imem_rdata;
          pc_out      <= issue_pc;
          instr_valid <= 1'b1;
        end else begin
          instr       <= NOP_INSTR;
          instr_valid <= 1'b0;
        end
      end else if (take_word) begin
        skid_data  <= imem_rdata;
        skid_pc    <= issue_pc;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. A behavioural imem answers every grant with rvalid a
// programmable number of cycles later; expected (instr, pc_out) pairs are queued by the
// stimulus and popped by a monitor whenever decode accepts a word.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [21:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [21:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [21:0] pc_out;
  logic        halted;

  // second instance with RESET_PC at the top of the address space
  logic        req2;
  logic [21:0] addr2;
  logic        gnt2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic        valid2;
  logic [21:0] pc_out2;
  logic        halted2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_i[$];
  logic [21:0] exp_pc[$];
  logic [21:0] addr_log[$];
  logic [21:0] addr_log2[$];
  int unsigned mem_lat = 0;

  if_fetch #(.PC_W(22), .RESET_PC(22'h000000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
  );

  if_fetch #(.PC_W(22), .RESET_PC(22'h3FFFFF), .NOP_INSTR(NOP)) u_dut_w (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(22'h000000),
    .halt(1'b0), .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .instr(instr2),
    .instr_valid(valid2), .pc_out(pc_out2), .halted(halted2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] data_of(input logic [21:0] a);
    return 32'h0844_0000 + {10'd0, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [21:0] a);
    exp_i.push_back(d);
    exp_pc.push_back(a);
  endtask

  // advance to 2 time units after the next n rising edges
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_i.size() != 0 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("drain_pending", exp_i.size(), 0);
  endtask

  // imem models: grant completes at the rising edge, rvalid follows after mem_lat cycles
  logic        hs, hs2, pend;
  logic [21:0] ha, ha2, pend_addr;
  int unsigned pend_cnt;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    rvalid2     = 1'b0;
    rdata2      = '0;
    pend        = 1'b0;
    pend_cnt    = 0;
    pend_addr   = '0;
    forever begin
      @(negedge clk);
      hs  = imem_req && imem_gnt;
      ha  = imem_addr;
      hs2 = req2 && gnt2;
      ha2 = addr2;
      @(posedge clk);
      #1;
      if (hs) begin
        pend      = 1'b1;
        pend_cnt  = mem_lat;
        pend_addr = ha;
        addr_log.push_back(ha);
      end
      if (pend && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = data_of(pend_addr);
        pend        = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pend) pend_cnt--;
      end
      rvalid2 = hs2;
      rdata2  = hs2 ? data_of(ha2) : 32'h0;
      if (hs2) addr_log2.push_back(ha2);
    end
  end

  // monitor: a word is consumed when valid and not stalled
  logic [31:0] e_i;
  logic [21:0] e_pc;
  always @(negedge clk) begin
    if (rst) begin
      if (instr_valid && !stall) begin
        if (exp_i.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got instr %h pc_out %h, required none (t=%0t)",
                   instr, pc_out, $time);
        end else begin
          e_i  = exp_i.pop_front();
          e_pc = exp_pc.pop_front();
          chk("instr", instr, e_i);
          chk("pc_out", 32'(pc_out), 32'(e_pc));
        end
      end else if (!instr_valid) begin
        chk("nop_when_invalid", instr, NOP);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d words outstanding", exp_i.size());
    $fatal(1);
  end

  logic [7:0]  pat;
  int unsigned req_cnt;
  int unsigned log_sz;

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    imem_gnt    = 1'b1;
    gnt2        = 1'b1;
    pat         = '0;

    // 1: reset values, then back-to-back fetch with gnt every cycle
    tick(2);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_out", 32'(pc_out), 0);
    chk("rst_halted", 32'(halted), 0);
    push(data_of(22'd0), 22'd0);
    push(data_of(22'd1), 22'd1);
    push(data_of(22'd2), 22'd2);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 6) begin
        imem_gnt = 1'b0;
        gnt2     = 1'b0;
      end
      #3;
      pat[i-1] = instr_valid;
      if (i == 3) begin
        chk("wrap_first_valid", 32'(valid2), 1);
        chk("wrap_first_pc_out", 32'(pc_out2), 32'h003F_FFFF);
        chk("wrap_first_instr", instr2, 32'h0883_FFFF);
        chk("wrap_halted", 32'(halted2), 0);
      end
    end
    chk("valid_pattern", 32'(pat), 32'h54);
    chk("log_size", addr_log.size(), 3);
    chk("log_addr0", 32'(addr_log[0]), 0);
    chk("log_addr1", 32'(addr_log[1]), 1);
    chk("log_addr2", 32'(addr_log[2]), 2);
    chk("req_held", 32'(imem_req), 1);
    chk("addr_held", 32'(imem_addr), 3);
    chk("wrap_addr0", 32'(addr_log2[0]), 32'h003F_FFFF);
    chk("wrap_addr1", 32'(addr_log2[1]), 0);
    wait_drain(20);

    // 2: stall for 5 cycles while a word is held; next word goes to the skid register
    tick(1);
    redirect    = 1'b1;
    redirect_pc = 22'd1;
    tick(1);
    redirect = 1'b0;
    imem_gnt = 1'b1;
    push(32'h0844_0001, 22'd1);
    push(32'h0844_0002, 22'd2);
    tick(2);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("stall_instr", instr, 32'h0844_0001);
      chk("stall_pc_out", 32'(pc_out), 1);
      chk("stall_valid", 32'(instr_valid), 1);
      if (k > 0) chk("stall_no_req", 32'(imem_req), 0);
      tick(1);
    end
    stall    = 1'b0;
    imem_gnt = 1'b0;
    wait_drain(20);

    // 3: redirect while a request is outstanding
    tick(1);
    mem_lat  = 2;
    imem_gnt = 1'b1;
    tick(1);
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 22'h000100;
    tick(1);
    redirect = 1'b0;
    #3;
    chk("redir_valid0", 32'(instr_valid), 0);
    tick(1);
    #3;
    chk("redir_valid1", 32'(instr_valid), 0);
    chk("redir_wait_req", 32'(imem_req), 0);
    tick(1);
    mem_lat  = 0;
    imem_gnt = 1'b1;
    push(data_of(22'h000100), 22'h000100);
    #3;
    chk("redir_req", 32'(imem_req), 1);
    chk("redir_addr", 32'(imem_addr), 32'h100);
    chk("redir_valid2", 32'(instr_valid), 0);
    tick(1);
    imem_gnt = 1'b0;
    wait_drain(20);
    chk("redir_log_last", 32'(addr_log[addr_log.size()-1]), 32'h100);

    // 4: halt with a request outstanding
    tick(1);
    log_sz   = addr_log.size();
    mem_lat  = 2;
    imem_gnt = 1'b1;
    tick(1);
    imem_gnt = 1'b0;
    halt     = 1'b1;
    tick(1);
    imem_gnt = 1'b1;
    #3;
    chk("halt_pending0", 32'(halted), 0);
    tick(1);
    #3;
    chk("halt_pending1", 32'(halted), 0);
    tick(1);
    #3;
    chk("halted", 32'(halted), 1);
    chk("halted_valid", 32'(instr_valid), 0);
    req_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      #3;
      if (imem_req) req_cnt++;
    end
    chk("halted_req_cycles", req_cnt, 0);
    chk("halted_still", 32'(halted), 1);
    chk("halted_no_new_grants", addr_log.size(), log_sz + 1);

    // 6: reset in the middle of WAIT with a word held under stall
    tick(1);
    halt     = 1'b0;
    imem_gnt = 1'b0;
    mem_lat  = 0;
    rst      = 1'b0;
    #1;
    chk("rst_clears_halted", 32'(halted), 0);
    tick(1);
    rst = 1'b1;
    tick(1);
    redirect    = 1'b1;
    redirect_pc = 22'h000155;
    tick(1);
    redirect = 1'b0;
    imem_gnt = 1'b1;
    tick(2);
    stall   = 1'b1;
    mem_lat = 3;
    #3;
    chk("pre_rst_valid", 32'(instr_valid), 1);
    chk("pre_rst_pc_out", 32'(pc_out), 32'h155);
    tick(1);
    imem_gnt = 1'b0;
    tick(1);
    rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 0);
    chk("async_rst_valid", 32'(instr_valid), 0);
    chk("async_rst_instr", instr, NOP);
    chk("async_rst_pc_out", 32'(pc_out), 0);
    chk("async_rst_halted", 32'(halted), 0);
    chk("async_rst_addr", 32'(imem_addr), 0);
    tick(1);
    rst   = 1'b1;
    stall = 1'b0;
    tick(2);
    mem_lat  = 0;
    imem_gnt = 1'b1;
    push(data_of(22'd0), 22'd0);
    tick(1);
    imem_gnt = 1'b0;
    wait_drain(20);
    chk("restart_addr", 32'(addr_log[addr_log.size()-1]), 0);

    // 5: redirect and halt in the same cycle: redirect wins
    tick(1);
    redirect    = 1'b1;
    redirect_pc = 22'h0002A0;
    halt        = 1'b1;
    tick(1);
    redirect = 1'b0;
    halt     = 1'b0;
    imem_gnt = 1'b1;
    push(data_of(22'h0002A0), 22'h0002A0);
    #3;
    chk("redir_halt_halted", 32'(halted), 0);
    chk("redir_halt_req", 32'(imem_req), 1);
    chk("redir_halt_addr", 32'(imem_addr), 32'h2A0);
    tick(1);
    imem_gnt = 1'b0;
    wait_drain(20);
    chk("redir_halt_not_halted", 32'(halted), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
